branch_resolve_unit: RTL and testbench

//  Parametrised, pipelined branch resolution stage at the ID/EX boundary.
//  - Evaluates RV32I/RV64I conditional branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
//  - Computes the resolved target and compares it with the front-end prediction.
//  - Emits a mispredict redirect and keeps saturating branch/mispredict counters.
//  - Uses a valid/ready handshake, an optional output register and a kill input.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_cmp.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 123 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Branch condition encodings and the result record produced by the resolve stage.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Widest supported PC; narrower configurations use the low bits of redirect_pc.
  localparam int MAX_XLEN = 64;

  typedef struct packed {
    logic                taken;
    logic                mispredict;
    logic                illegal;
    logic [MAX_XLEN-1:0] redirect_pc;
  } br_result_t;

  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator and funct3 decode that produce the resolved branch direction.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_branch_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq;
  logic lt;
  logic ltu;
  logic cond;

  assign eq  = (rs1_i == rs2_i);
  assign lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign ltu = (rs1_i < rs2_i);

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      BEQ:     cond = eq;
      BNE:     cond = !eq;
      BLT:     cond = lt;
      BGE:     cond = !lt;
      BLTU:    cond = ltu;
      BGEU:    cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign illegal_o = is_branch_i && is_illegal_f3(funct3_i);
  assign taken_o   = is_branch_i && !illegal_o && cond;

endmodule

// File: rtl/branch_resolve_unit.sv
// ID/EX branch resolution: target adders, optional output register, handshake and
// saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PIPE  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1Data,
  input  logic [XLEN-1:0]  rs2Data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  logic             cmpTaken;
  logic             cmpIllegal;
  logic [XLEN-1:0]  tgt;
  logic [XLEN-1:0]  seqPc;
  br_result_t       result_d;
  br_result_t       resultOut;
  logic             resIsBranch;
  logic             handshake;
  logic             unusedRedirectHi;
  logic [CNT_W-1:0] brCnt_q;
  logic [CNT_W-1:0] mpCnt_q;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .is_branch_i (is_branch),
    .funct3_i    (funct3),
    .rs1_i       (rs1Data),
    .rs2_i       (rs2Data),
    .taken_o     (cmpTaken),
    .illegal_o   (cmpIllegal)
  );

  assign tgt   = pc + imm;
  assign seqPc = pc + XLEN'(4);

  // A non-branch predicted taken also mispredicts, since taken is forced low for it.
  always_comb begin
    result_d             = '0;
    result_d.taken       = cmpTaken;
    result_d.illegal     = cmpIllegal;
    result_d.redirect_pc = MAX_XLEN'(cmpTaken ? tgt : seqPc);
    result_d.mispredict  = !cmpIllegal &&
                           ((cmpTaken != pred_taken) || (cmpTaken && (pred_target != tgt)));
  end

  if (PIPE != 0) begin : g_pipe
    logic       outValid_q;
    logic       isBranch_q;
    br_result_t result_q;
    logic       accept;

    assign in_ready = !outValid_q || out_ready;
    assign accept   = in_valid && in_ready && !kill;

    // Kill wins over both a same-cycle accept and a same-cycle drain.
    always_ff @(posedge clk) begin
      if (rst) begin
        outValid_q <= 1'b0;
        isBranch_q <= 1'b0;
        result_q   <= '0;
      end else if (kill) begin
        outValid_q <= 1'b0;
      end else if (accept) begin
        outValid_q <= 1'b1;
        isBranch_q <= is_branch;
        result_q   <= result_d;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end

    assign out_valid   = outValid_q;
    assign resultOut   = result_q;
    assign resIsBranch = isBranch_q;
  end else begin : g_comb
    assign out_valid   = in_valid && !kill;
    assign in_ready    = out_ready;
    assign resultOut   = result_d;
    assign resIsBranch = is_branch;
  end

  assign handshake = out_valid && out_ready && !kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      brCnt_q <= '0;
      mpCnt_q <= '0;
    end else if (handshake) begin
      if (resIsBranch && (brCnt_q != '1)) brCnt_q <= brCnt_q + CNT_W'(1);
      if (resultOut.mispredict && (mpCnt_q != '1)) mpCnt_q <= mpCnt_q + CNT_W'(1);
    end
  end

  assign taken            = resultOut.taken;
  assign mispredict       = resultOut.mispredict;
  assign illegal          = resultOut.illegal;
  assign redirect_pc      = resultOut.redirect_pc[XLEN-1:0];
  assign unusedRedirectHi = ^resultOut.redirect_pc;
  assign br_cnt           = brCnt_q;
  assign mp_cnt           = mpCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven scoreboard bench for branch_resolve_unit: pipelined 16/4-bit counter
// instances share one stimulus stream, a combinational instance is checked separately.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  typedef struct {
    logic        isBr;
    logic [2:0]  f3;
    logic [31:0] a, b, pcv, immv;
    logic        pt;
    logic [31:0] ptgt;
    logic        eTaken, eMp, eIll;
    logic [31:0] eRedir;
  } vec_t;

  typedef struct {
    logic        isBr, taken, mp, ill;
    logic [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        inValid, outReady, kill, isBranch, predTaken;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm, predTarget;

  logic        inReady, outValid, taken, mispredict, illegal;
  logic [31:0] redirectPc;
  logic [15:0] brCnt, mpCnt;

  logic        sInReady, sOutValid, sTaken, sMp, sIll;
  logic [31:0] sRedir;
  logic [3:0]  sBrCnt, sMpCnt;

  logic        cInValid, cOutReady, cKill, cInReady, cOutValid, cTaken, cMp, cIll;
  logic [31:0] cRedir;
  logic [15:0] cBrCnt, cMpCnt;

  branch_resolve_unit #(.XLEN(32), .PIPE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .is_branch(isBranch),
    .funct3(funct3), .rs1Data(rs1), .rs2Data(rs2), .pc(pc), .imm(imm),
    .pred_taken(predTaken), .pred_target(predTarget), .kill(kill), .out_valid(outValid),
    .out_ready(outReady), .taken(taken), .mispredict(mispredict), .redirect_pc(redirectPc),
    .illegal(illegal), .br_cnt(brCnt), .mp_cnt(mpCnt)
  );

  branch_resolve_unit #(.XLEN(32), .PIPE(1), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(sInReady), .is_branch(isBranch),
    .funct3(funct3), .rs1Data(rs1), .rs2Data(rs2), .pc(pc), .imm(imm),
    .pred_taken(predTaken), .pred_target(predTarget), .kill(kill), .out_valid(sOutValid),
    .out_ready(outReady), .taken(sTaken), .mispredict(sMp), .redirect_pc(sRedir),
    .illegal(sIll), .br_cnt(sBrCnt), .mp_cnt(sMpCnt)
  );

  branch_resolve_unit #(.XLEN(32), .PIPE(0), .CNT_W(16)) dutComb (
    .clk(clk), .rst(rst), .in_valid(cInValid), .in_ready(cInReady), .is_branch(isBranch),
    .funct3(funct3), .rs1Data(rs1), .rs2Data(rs2), .pc(pc), .imm(imm),
    .pred_taken(predTaken), .pred_target(predTarget), .kill(cKill), .out_valid(cOutValid),
    .out_ready(cOutReady), .taken(cTaken), .mispredict(cMp), .redirect_pc(cRedir),
    .illegal(cIll), .br_cnt(cBrCnt), .mp_cnt(cMpCnt)
  );

  vec_t vecs[16];
  vec_t idle;
  exp_t sbq[$];
  int   vecCount = 0;
  int   errCount = 0;
  logic modelValid;
  int   modelBr, modelMp, cModelBr, cModelMp;

  function automatic vec_t mk(input logic isBr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pcv, input logic [31:0] immv,
                              input logic pt, input logic [31:0] ptgt,
                              input logic eT, input logic eM, input logic eI,
                              input logic [31:0] eR);
    vec_t v;
    v.isBr = isBr; v.f3 = f3; v.a = a; v.b = b; v.pcv = pcv; v.immv = immv;
    v.pt = pt; v.ptgt = ptgt; v.eTaken = eT; v.eMp = eM; v.eIll = eI; v.eRedir = eR;
    return v;
  endfunction

  function automatic logic [15:0] sat(input int v, input int mx);
    return (v > mx) ? 16'(mx) : 16'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveVec(input vec_t v);
    isBranch = v.isBr; funct3 = v.f3; rs1 = v.a; rs2 = v.b; pc = v.pcv; imm = v.immv;
    predTaken = v.pt; predTarget = v.ptgt;
  endtask

  // One cycle on the pipelined pair: drive, check against the model, advance the model.
  task automatic applyStimulus(input vec_t v, input logic valid, input logic ready, input logic k);
    logic expReady;
    exp_t e;
    driveVec(v);
    inValid = valid; outReady = ready; kill = k;
    #1;
    expReady = !modelValid || ready;
    checkOutput("in_ready", inReady, expReady);
    checkOutput("sat_in_ready", sInReady, expReady);
    checkOutput("out_valid", outValid, modelValid);
    checkOutput("sat_out_valid", sOutValid, modelValid);
    if (modelValid && sbq.size() > 0) begin
      e = sbq[0];
      checkOutput("taken", taken, e.taken);
      checkOutput("mispredict", mispredict, e.mp);
      checkOutput("illegal", illegal, e.ill);
      checkOutput("redirect_pc", redirectPc, e.redir);
      checkOutput("sat_redirect_pc", sRedir, e.redir);
      checkOutput("sat_mispredict", sMp, e.mp);
    end
    checkOutput("br_cnt", brCnt, sat(modelBr, 65535));
    checkOutput("mp_cnt", mpCnt, sat(modelMp, 65535));
    checkOutput("sat_br_cnt", sBrCnt, sat(modelBr, 15));
    checkOutput("sat_mp_cnt", sMpCnt, sat(modelMp, 15));
    if (k) begin
      if (modelValid && sbq.size() > 0) void'(sbq.pop_front());
      modelValid = 1'b0;
    end else begin
      if (modelValid && ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        modelBr += int'(e.isBr);
        modelMp += int'(e.mp);
        modelValid = 1'b0;
      end
      if (valid && expReady) begin
        e.isBr = v.isBr; e.taken = v.eTaken; e.mp = v.eMp; e.ill = v.eIll; e.redir = v.eRedir;
        sbq.push_back(e);
        modelValid = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic checkComb(input vec_t v, input logic ready, input logic k);
    driveVec(v);
    cInValid = 1'b1; cOutReady = ready; cKill = k;
    #1;
    checkOutput("comb_out_valid", cOutValid, !k);
    checkOutput("comb_in_ready", cInReady, ready);
    checkOutput("comb_br_cnt", cBrCnt, sat(cModelBr, 65535));
    checkOutput("comb_mp_cnt", cMpCnt, sat(cModelMp, 65535));
    if (!k) begin
      checkOutput("comb_taken", cTaken, v.eTaken);
      checkOutput("comb_mispredict", cMp, v.eMp);
      checkOutput("comb_illegal", cIll, v.eIll);
      checkOutput("comb_redirect_pc", cRedir, v.eRedir);
      if (ready) begin
        cModelBr += int'(v.isBr);
        cModelMp += int'(v.eMp);
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; kill = 1'b0;
    cInValid = 1'b0; cOutReady = 1'b0; cKill = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelValid = 1'b0; sbq.delete(); modelBr = 0; modelMp = 0;
  endtask

  initial begin
    vecs[0]  = mk(1, BEQ,  32'h5, 32'h5, 32'h100, 32'h20, 0, 32'h0, 1, 1, 0, 32'h120);
    vecs[1]  = mk(1, BLT,  32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 1, 32'h210, 1, 0, 0, 32'h210);
    vecs[2]  = mk(1, BLTU, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 1, 32'h210, 0, 1, 0, 32'h204);
    vecs[3]  = mk(1, BGEU, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 0, 32'h0, 1, 1, 0, 32'h210);
    vecs[4]  = mk(1, BNE,  32'h5, 32'h5, 32'h100, 32'h20, 0, 32'h0, 0, 0, 0, 32'h104);
    vecs[5]  = mk(1, BEQ,  32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 1, 32'h4, 1, 0, 0, 32'h4);
    vecs[6]  = mk(1, BGE,  32'h80000000, 32'h7FFFFFFF, 32'h300, 32'hFFFFFFF0, 0, 32'h0, 0, 0, 0, 32'h304);
    vecs[7]  = mk(1, BLT,  32'h80000000, 32'h7FFFFFFF, 32'h300, 32'hFFFFFFF0, 1, 32'h2F0, 1, 0, 0, 32'h2F0);
    vecs[8]  = mk(1, BLT,  32'h1, 32'h2, 32'h400, 32'h40, 1, 32'h500, 1, 1, 0, 32'h440);
    vecs[9]  = mk(0, BEQ,  32'h0, 32'h0, 32'h500, 32'h0, 1, 32'h600, 0, 1, 0, 32'h504);
    vecs[10] = mk(1, 3'b010, 32'h0, 32'h0, 32'h600, 32'h10, 1, 32'h610, 0, 0, 1, 32'h604);
    vecs[11] = mk(0, BEQ,  32'h0, 32'h0, 32'h700, 32'h0, 0, 32'h0, 0, 0, 0, 32'h704);
    vecs[12] = mk(1, BLTU, 32'h1, 32'hFFFFFFFF, 32'h800, 32'h8, 1, 32'h808, 1, 0, 0, 32'h808);
    vecs[13] = mk(1, BGE,  32'h3, 32'h3, 32'h900, 32'h100, 0, 32'h0, 1, 1, 0, 32'hA00);
    vecs[14] = mk(1, BGEU, 32'h1, 32'h2, 32'hA00, 32'h4, 1, 32'hA04, 0, 1, 0, 32'hA04);
    vecs[15] = mk(1, 3'b011, 32'h3, 32'h3, 32'hB00, 32'h40, 0, 32'h0, 0, 0, 1, 32'hB04);
    idle     = mk(0, BEQ,  32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h4);
    cModelBr = 0; cModelMp = 0;
    driveVec(idle);
    doReset();
    @(negedge clk);
    doReset();

    applyStimulus(idle, 0, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], 1, 1, 0);
    applyStimulus(idle, 0, 1, 0);
    applyStimulus(idle, 0, 1, 0);

    applyStimulus(vecs[0], 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(vecs[1], 1, 0, 0);
    applyStimulus(vecs[1], 1, 1, 0);
    applyStimulus(idle, 0, 1, 0);
    applyStimulus(idle, 0, 1, 0);

    applyStimulus(vecs[8], 1, 1, 0);
    applyStimulus(vecs[3], 1, 1, 1);
    applyStimulus(idle, 0, 1, 0);
    applyStimulus(vecs[2], 1, 0, 0);
    applyStimulus(vecs[2], 1, 0, 1);
    applyStimulus(idle, 0, 1, 0);

    inValid = 1'b0;
    for (int i = 0; i < 16; i++) checkComb(vecs[i], 1, 0);
    checkComb(vecs[0], 1, 1);
    checkComb(vecs[3], 0, 0);
    checkComb(idle, 1, 1);
    cInValid = 1'b0;

    for (int i = 0; i < 20; i++) applyStimulus(vecs[0], 1, 1, 0);
    applyStimulus(idle, 0, 1, 0);
    applyStimulus(idle, 0, 1, 0);
    checkOutput("sat_mp_cnt_full", sMpCnt, 4'hF);
    checkOutput("sat_br_cnt_full", sBrCnt, 4'hF);

    applyStimulus(vecs[0], 1, 0, 0);
    doReset();
    applyStimulus(idle, 0, 1, 0);
    checkOutput("post_rst_mp_cnt", mpCnt, 16'h0);
    checkOutput("post_rst_sat_br_cnt", sBrCnt, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
